// File: rtl/neuron_trainer_param.sv
// Perceptron training engine for NIN signed inputs with a bipolar target.
// It saturates the weights, stops at an epoch limit and takes samples over a valid/ready handshake.
module neuron_trainer_param #(
   parameter int NIN   = 2,
   parameter int XW    = 7,
   parameter int WW    = 14,
   parameter int THETA = 0,
   parameter int CW    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CW-1:0]     nSamples,
   input  logic [CW-1:0]     maxEpochs,
   input  logic [NIN*XW-1:0] xBus,
   input  logic [1:0]        tBus,
   input  logic              sampleValid,
   output logic              readyToGetData,
   output logic [NIN*WW-1:0] W,
   output logic [WW-1:0]     Bias,
   output logic              updateState,
   output logic [CW-1:0]     epochCount,
   output logic              done,
   output logic              converged
);

   localparam int YW = WW + XW + $clog2(NIN) + 1;
   localparam int PW = WW + XW;
   localparam int SW = ((WW > XW) ? WW : XW) + 2;
   localparam logic signed [YW-1:0] TH_POS = YW'(THETA);
   localparam logic signed [YW-1:0] TH_NEG = -TH_POS;
   localparam logic signed [SW-1:0] W_MAX  = SW'((longint'(1) << (WW - 1)) - 1);
   localparam logic signed [SW-1:0] W_MIN  = ~W_MAX;

   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_WAIT, S_CALC, S_UPDATE, S_DONE
   } state_t;

   state_t state, state_next;

   logic [CW-1:0]          n_lat, max_lat, sample_cnt;
   logic [NIN*XW-1:0]      x_lat;
   logic [1:0]             t_lat;
   logic                   err_flag, upd_err, calc_err;
   logic                   last_sample, last_epoch, epoch_clean;
   logic signed [WW-1:0]   w_reg [NIN];
   logic signed [WW-1:0]   w_sat [NIN];
   logic signed [WW-1:0]   bias_reg, bias_sat;
   logic signed [YW-1:0]   yin;

   // The sum is kept one bit wider than needed so it can never wrap before clamping.
   function automatic logic signed [WW-1:0] sat_add(input logic signed [WW-1:0] a,
                                                    input logic signed [SW-1:0] d);
      logic signed [SW-1:0] s;
      s = SW'(a) + d;
      if (s > W_MAX)
         s = W_MAX;
      else if (s < W_MIN)
         s = W_MIN;
      return WW'(s);
   endfunction

   always_comb begin : mac_blk
      logic signed [XW-1:0] xi;
      logic signed [PW-1:0] prod;
      xi   = '0;
      prod = '0;
      yin  = YW'(bias_reg);
      for (int i = 0; i < NIN; i++) begin
         xi   = x_lat[i*XW +: XW];
         prod = PW'(w_reg[i]) * PW'(xi);
         yin  = yin + YW'(prod);
      end
   end

   always_comb begin
      calc_err = ((t_lat == 2'b01) && !(yin > TH_POS)) ||
                 ((t_lat == 2'b11) && !(yin < TH_NEG));
   end

   always_comb begin : upd_blk
      logic signed [XW-1:0] xs;
      logic signed [SW-1:0] xd;
      xs = '0;
      xd = '0;
      for (int i = 0; i < NIN; i++) begin
         xs       = x_lat[i*XW +: XW];
         xd       = SW'(xs);
         w_sat[i] = sat_add(w_reg[i], t_lat[1] ? -xd : xd);
      end
      bias_sat = sat_add(bias_reg, t_lat[1] ? -SW'(1) : SW'(1));
   end

   always_comb begin
      last_sample = (sample_cnt + CW'(1)) == n_lat;
      last_epoch  = (epochCount + CW'(1)) == max_lat;
      epoch_clean = !err_flag && !upd_err;
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   // The zero-length check looks at the live inputs because they are being latched this same cycle.
   always_comb begin
      state_next     = state;
      readyToGetData = (state == S_WAIT);
      updateState    = (state == S_UPDATE);
      done           = (state == S_DONE);
      case (state)
         S_IDLE:   if (start) state_next = S_INIT;
         S_INIT:   state_next = ((nSamples == '0) || (maxEpochs == '0)) ? S_DONE : S_WAIT;
         S_WAIT:   if (sampleValid) state_next = S_CALC;
         S_CALC:   state_next = S_UPDATE;
         S_UPDATE: state_next = (last_sample && (epoch_clean || last_epoch)) ? S_DONE : S_WAIT;
         S_DONE:   if (start) state_next = S_INIT;
         default:  state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NIN; i++) w_reg[i] <= '0;
         bias_reg   <= '0;
         sample_cnt <= '0;
         epochCount <= '0;
         err_flag   <= 1'b0;
         upd_err    <= 1'b0;
         converged  <= 1'b0;
         n_lat      <= '0;
         max_lat    <= '0;
         x_lat      <= '0;
         t_lat      <= '0;
      end else begin
         case (state)
            S_INIT: begin
               for (int i = 0; i < NIN; i++) w_reg[i] <= '0;
               bias_reg   <= '0;
               sample_cnt <= '0;
               epochCount <= '0;
               err_flag   <= 1'b0;
               converged  <= 1'b0;
               n_lat      <= nSamples;
               max_lat    <= maxEpochs;
            end
            S_WAIT: begin
               if (sampleValid) begin
                  x_lat <= xBus;
                  t_lat <= tBus;
               end
            end
            S_CALC: upd_err <= calc_err;
            S_UPDATE: begin
               if (upd_err) begin
                  for (int i = 0; i < NIN; i++) w_reg[i] <= w_sat[i];
                  bias_reg <= bias_sat;
                  err_flag <= 1'b1;
               end
               if (last_sample) begin
                  sample_cnt <= '0;
                  epochCount <= epochCount + CW'(1);
                  if (epoch_clean)
                     converged <= 1'b1;
                  else if (!last_epoch)
                     err_flag <= 1'b0;
               end else begin
                  sample_cnt <= sample_cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      W = '0;
      for (int i = 0; i < NIN; i++) W[i*WW +: WW] = w_reg[i];
      Bias = bias_reg;
   end

endmodule

// File: tb/tb_neuron_trainer_param.sv
// Bench for neuron_trainer_param: a cycle-level perceptron reference model compared every cycle,
// plus directed scenarios with hand-computed values and a narrow-weight saturation instance.
module tb_neuron_trainer_param;

   localparam int NIN = 2;
   localparam int XW  = 7;
   localparam int WW  = 14;
   localparam int CW  = 16;
   localparam int TH  = 0;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [CW-1:0]     nSamples = '0;
   logic [CW-1:0]     maxEpochs = '0;
   logic [NIN*XW-1:0] xBus = '0;
   logic [1:0]        tBus = '0;
   logic              sampleValid = 1'b0;
   logic              readyToGetData;
   logic [NIN*WW-1:0] W;
   logic [WW-1:0]     Bias;
   logic              updateState;
   logic [CW-1:0]     epochCount;
   logic              done;
   logic              converged;

   logic              start2 = 1'b0;
   logic [CW-1:0]     nSamples2 = '0;
   logic [CW-1:0]     maxEpochs2 = '0;
   logic [NIN*XW-1:0] xBus2 = '0;
   logic [1:0]        tBus2 = '0;
   logic              valid2 = 1'b0;
   logic              ready2;
   logic [7:0]        W2;
   logic [3:0]        Bias2;
   logic              upd2;
   logic [CW-1:0]     ep2;
   logic              done2;
   logic              conv2;

   always #5 clk = ~clk;

   neuron_trainer_param #(.NIN(NIN), .XW(XW), .WW(WW), .THETA(TH), .CW(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .nSamples(nSamples), .maxEpochs(maxEpochs),
      .xBus(xBus), .tBus(tBus), .sampleValid(sampleValid), .readyToGetData(readyToGetData),
      .W(W), .Bias(Bias), .updateState(updateState), .epochCount(epochCount),
      .done(done), .converged(converged)
   );

   neuron_trainer_param #(.NIN(2), .XW(7), .WW(4), .THETA(1000), .CW(CW)) dut_sat (
      .clk(clk), .rst(rst), .start(start2), .nSamples(nSamples2), .maxEpochs(maxEpochs2),
      .xBus(xBus2), .tBus(tBus2), .sampleValid(valid2), .readyToGetData(ready2),
      .W(W2), .Bias(Bias2), .updateState(upd2), .epochCount(ep2),
      .done(done2), .converged(conv2)
   );

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;
   int dut_hs = 0;

   task automatic check_value(input string name, input logic signed [31:0] actual,
                              input logic signed [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic report_timeout(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: bound expired at %0t", name, $time);
   endtask

   function automatic int sat(input int v, input int w);
      int hi, lo;
      hi = (1 << (w - 1)) - 1;
      lo = -(1 << (w - 1));
      return (v > hi) ? hi : ((v < lo) ? lo : v);
   endfunction

   // Reference model: perceptron rule on plain integers with a simple busy countdown for timing.
   int m_w[NIN];
   int m_b, m_ep, m_ns, m_me, m_cnt, m_stage, mx0, mx1;
   bit m_err, m_done, m_conv, m_ready, m_upd, m_init, m_idle;
   logic [1:0] mt;

   always @(posedge clk) begin
      int yin, y, tv;
      if (rst) begin
         m_w = '{default: 0};
         m_b = 0; m_ep = 0; m_cnt = 0; m_stage = 0;
         m_err = 0; m_done = 0; m_conv = 0; m_ready = 0; m_upd = 0; m_init = 0;
      end else if (m_init) begin
         m_init = 0;
         m_w = '{default: 0};
         m_b = 0; m_ep = 0; m_cnt = 0; m_err = 0; m_conv = 0;
         m_ns = int'(nSamples);
         m_me = int'(maxEpochs);
         if (m_ns == 0 || m_me == 0) m_done = 1;
         else m_ready = 1;
      end else if (m_ready && sampleValid) begin
         mx0 = $signed(xBus[6:0]);
         mx1 = $signed(xBus[13:7]);
         mt = tBus;
         m_ready = 0;
         m_stage = 1;
      end else if (m_stage == 1) begin
         m_stage = 2;
         m_upd = 1;
      end else if (m_stage == 2) begin
         m_stage = 0;
         m_upd = 0;
         yin = m_b + m_w[0] * mx0 + m_w[1] * mx1;
         y = (yin > TH) ? 1 : ((yin < -TH) ? -1 : 0);
         tv = (mt == 2'b01) ? 1 : ((mt == 2'b11) ? -1 : 0);
         if (tv != 0 && y != tv) begin
            m_w[0] = sat(m_w[0] + tv * mx0, WW);
            m_w[1] = sat(m_w[1] + tv * mx1, WW);
            m_b = sat(m_b + tv, WW);
            m_err = 1;
         end
         m_cnt++;
         if (m_cnt == m_ns) begin
            m_cnt = 0;
            m_ep++;
            if (!m_err) begin
               m_conv = 1; m_done = 1;
            end else if (m_ep == m_me) begin
               m_done = 1;
            end else begin
               m_err = 0; m_ready = 1;
            end
         end else begin
            m_ready = 1;
         end
      end else if (start && !m_ready) begin
         m_init = 1;
         m_done = 0;
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         check_value("W0", $signed(W[13:0]), m_w[0]);
         check_value("W1", $signed(W[27:14]), m_w[1]);
         check_value("Bias", $signed(Bias), m_b);
         check_value("epochCount", epochCount, m_ep);
         check_value("done", done, m_done);
         check_value("converged", converged, m_conv);
         check_value("readyToGetData", readyToGetData, m_ready);
         check_value("updateState", updateState, m_upd);
      end
   end

   always @(negedge clk) begin
      if (!rst && sampleValid && readyToGetData) dut_hs++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      start = 1'b0;
      sampleValid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic do_start(input int ns, input int me);
      nSamples = 16'(ns);
      maxEpochs = 16'(me);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Returns one ns after the accepting edge, i.e. in the CALC cycle.
   task automatic apply_stimulus(input int x0, input int x1, input logic [1:0] t, input int gap);
      bit ok;
      ok = 1'b0;
      sampleValid = 1'b0;
      repeat (gap) tick();
      xBus = {7'(x1), 7'(x0)};
      tBus = t;
      sampleValid = 1'b1;
      for (int c = 0; c < 100 && !ok; c++) begin
         @(negedge clk);
         if (readyToGetData === 1'b1) ok = 1'b1;
         tick();
      end
      if (!ok) report_timeout("handshake");
      sampleValid = 1'b0;
   endtask

   // Walks through CALC and UPDATE, optionally offering junk samples and start pulses there.
   task automatic settle(input bit hold, input bit pulse);
      sampleValid = hold;
      xBus = 14'($urandom);
      tBus = 2'($urandom);
      start = pulse;
      tick();
      tick();
      sampleValid = 1'b0;
      start = 1'b0;
   endtask

   int tab_x0[4], tab_x1[4];
   logic [1:0] tab_t[4];

   task automatic run_table(input int max_sends);
      for (int s = 0; s < max_sends && done !== 1'b1; s++) begin
         apply_stimulus(tab_x0[s % 4], tab_x1[s % 4], tab_t[s % 4], s % 2);
         settle(s % 3 == 0, 1'b0);
      end
      if (done !== 1'b1) report_timeout("table_done");
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int hs0, yin, y, ns, me, x0, x1;
      logic [1:0] tcodes[6];
      tcodes[0] = 2'b01; tcodes[1] = 2'b11; tcodes[2] = 2'b01;
      tcodes[3] = 2'b11; tcodes[4] = 2'b00; tcodes[5] = 2'b10;

      do_reset();
      check_en = 1'b1;
      check_value("rst_W", W, 0);
      check_value("rst_Bias", Bias, 0);
      check_value("rst_done", done, 0);
      check_value("rst_ready", readyToGetData, 0);

      // Two hand-worked samples
      do_start(2, 1);
      apply_stimulus(1, 1, 2'b01, 0);
      settle(1'b0, 1'b0);
      check_value("s1_W0", $signed(W[13:0]), 1);
      check_value("s1_W1", $signed(W[27:14]), 1);
      check_value("s1_Bias", $signed(Bias), 1);
      apply_stimulus(1, -1, 2'b11, 0);
      settle(1'b0, 1'b0);
      check_value("s2_W0", $signed(W[13:0]), 0);
      check_value("s2_W1", $signed(W[27:14]), 2);
      check_value("s2_Bias", $signed(Bias), 0);
      check_value("s2_done", done, 1);
      check_value("s2_conv", converged, 0);

      // Zero-length runs finish two cycles after start
      do_start(0, 5);
      check_value("z_done_c1", done, 0);
      tick();
      check_value("z_done_c2", done, 1);
      check_value("z_conv", converged, 0);
      check_value("z_W", W, 0);
      do_start(3, 0);
      tick();
      check_value("zm_done", done, 1);
      check_value("zm_ep", epochCount, 0);

      // Invalid target leaves the weights alone
      do_start(2, 1);
      apply_stimulus(1, 1, 2'b01, 1);
      settle(1'b0, 1'b0);
      apply_stimulus(5, -3, 2'b00, 0);
      settle(1'b0, 1'b0);
      check_value("inv_W0", $signed(W[13:0]), 1);
      check_value("inv_W1", $signed(W[27:14]), 1);
      check_value("inv_Bias", $signed(Bias), 1);
      check_value("inv_done", done, 1);

      // start in WAIT is ignored, then reset hits during CALC
      do_start(3, 2);
      apply_stimulus(1, 1, 2'b01, 0);
      settle(1'b0, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check_value("wstart_ready", readyToGetData, 1);
      check_value("wstart_W0", $signed(W[13:0]), 1);
      apply_stimulus(2, 3, 2'b01, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_value("calc_rst_W", W, 0);
      check_value("calc_rst_Bias", Bias, 0);
      check_value("calc_rst_ready", readyToGetData, 0);
      check_value("calc_rst_upd", updateState, 0);

      // Idle source: engine waits without advancing
      do_start(2, 1);
      tick();
      for (int c = 0; c < 5; c++) begin
         check_value("hold_ready", readyToGetData, 1);
         check_value("hold_upd", updateState, 0);
         tick();
      end
      apply_stimulus(3, 2, 2'b11, 0);
      settle(1'b1, 1'b0);
      apply_stimulus(-2, 4, 2'b01, 0);
      settle(1'b1, 1'b0);
      check_value("hold_done", done, 1);

      // Bipolar AND converges
      tab_x0[0] = 1;  tab_x1[0] = 1;  tab_t[0] = 2'b01;
      tab_x0[1] = 1;  tab_x1[1] = -1; tab_t[1] = 2'b11;
      tab_x0[2] = -1; tab_x1[2] = 1;  tab_t[2] = 2'b11;
      tab_x0[3] = -1; tab_x1[3] = -1; tab_t[3] = 2'b11;
      do_start(4, 10);
      run_table(40);
      check_value("and_conv", converged, 1);
      check_value("and_ep_le3", epochCount <= 3, 1);
      check_value("and_ep", epochCount, 2);
      check_value("and_W0", $signed(W[13:0]), 1);
      check_value("and_W1", $signed(W[27:14]), 1);
      check_value("and_Bias", $signed(Bias), -1);
      for (int s = 0; s < 4; s++) begin
         yin = $signed(Bias) + $signed(W[13:0]) * tab_x0[s] + $signed(W[27:14]) * tab_x1[s];
         y = (yin > TH) ? 1 : ((yin < -TH) ? -1 : 0);
         check_value("and_y_eq_t", y, (tab_t[s] == 2'b01) ? 1 : -1);
      end

      // Bipolar XOR never converges
      tab_t[0] = 2'b11; tab_t[1] = 2'b01; tab_t[2] = 2'b01; tab_t[3] = 2'b11;
      hs0 = dut_hs;
      do_start(4, 5);
      run_table(30);
      check_value("xor_conv", converged, 0);
      check_value("xor_ep", epochCount, 5);
      check_value("xor_hs", dut_hs - hs0, 20);

      // Randomised runs against the model
      for (int r = 0; r < 12; r++) begin
         ns = $urandom_range(1, 6);
         me = $urandom_range(1, 4);
         do_start(ns, me);
         for (int s = 0; s < ns * me + 2 && done !== 1'b1; s++) begin
            if (r % 2 == 0) begin
               x0 = int'($urandom_range(0, 6)) - 3;
               x1 = int'($urandom_range(0, 6)) - 3;
            end else begin
               x0 = int'($urandom_range(0, 127)) - 64;
               x1 = int'($urandom_range(0, 127)) - 64;
            end
            apply_stimulus(x0, x1, tcodes[$urandom_range(0, 5)], $urandom_range(0, 2));
            settle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end
         if (done !== 1'b1) report_timeout("rand_done");
      end

      // Narrow weights saturate instead of wrapping
      nSamples2 = 16'd10;
      maxEpochs2 = 16'd1;
      xBus2 = {7'd7, 7'd7};
      tBus2 = 2'b01;
      valid2 = 1'b1;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      for (int c = 0; c < 200 && done2 !== 1'b1; c++) begin
         check_value("sat_nonneg", {W2[7], W2[3], Bias2[3]}, 0);
         tick();
      end
      if (done2 !== 1'b1) report_timeout("sat_done");
      valid2 = 1'b0;
      check_value("sat_W0", $signed(W2[3:0]), 7);
      check_value("sat_W1", $signed(W2[7:4]), 7);
      check_value("sat_Bias", $signed(Bias2), 7);
      check_value("sat_conv", conv2, 0);
      check_value("sat_ep", ep2, 1);

      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
